// File: rtl/wb_6522_via_pkg.sv
// Shared constants for the wb_6522_via Wishbone VIA: register offsets, IFR bit
// positions and CA2/CB2 control-line mode encodings.
package wb_6522_via_pkg;

  localparam logic [3:0] REG_ORB    = 4'h0;
  localparam logic [3:0] REG_ORA    = 4'h1;
  localparam logic [3:0] REG_DDRB   = 4'h2;
  localparam logic [3:0] REG_DDRA   = 4'h3;
  localparam logic [3:0] REG_T1CL   = 4'h4;
  localparam logic [3:0] REG_T1CH   = 4'h5;
  localparam logic [3:0] REG_T1LL   = 4'h6;
  localparam logic [3:0] REG_T1LH   = 4'h7;
  localparam logic [3:0] REG_T2CL   = 4'h8;
  localparam logic [3:0] REG_T2CH   = 4'h9;
  localparam logic [3:0] REG_SR     = 4'hA;
  localparam logic [3:0] REG_ACR    = 4'hB;
  localparam logic [3:0] REG_PCR    = 4'hC;
  localparam logic [3:0] REG_IFR    = 4'hD;
  localparam logic [3:0] REG_IER    = 4'hE;
  localparam logic [3:0] REG_ORA_NH = 4'hF;

  localparam int IFR_CA2 = 0;
  localparam int IFR_CA1 = 1;
  localparam int IFR_SR  = 2;
  localparam int IFR_CB2 = 3;
  localparam int IFR_CB1 = 4;
  localparam int IFR_T2  = 5;
  localparam int IFR_T1  = 6;
  localparam int IFR_IRQ = 7;

  typedef enum logic [2:0] {
    C2_IN_NEG     = 3'b000,
    C2_IN_NEG_IND = 3'b001,
    C2_IN_POS     = 3'b010,
    C2_IN_POS_IND = 3'b011,
    C2_HANDSHAKE  = 3'b100,
    C2_PULSE      = 3'b101,
    C2_LOW        = 3'b110,
    C2_HIGH       = 3'b111
  } c2_mode_e;

  // Independent input modes leave the C2 flag alone on port access.
  function automatic logic c2_independent(input c2_mode_e m);
    return (m == C2_IN_NEG_IND) || (m == C2_IN_POS_IND);
  endfunction

endpackage

// File: rtl/via_port_ctl.sv
// One VIA port: OR/DDR storage, pin and control-line synchronizers, C1/C2 edge
// detection and the C2 output modes (handshake, pulse, fixed level).
module via_port_ctl
  import wb_6522_via_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_or,
  input  logic       wr_ddr,
  input  logic [7:0] wdata,
  input  logic [7:0] pin_in,
  input  logic       c1_in,
  input  logic       c2_in,
  input  logic       c1_pos,
  input  c2_mode_e   c2_mode,
  input  logic       hs_access,
  output logic [7:0] or_q,
  output logic [7:0] ddr_q,
  output logic [7:0] pin_sync,
  output logic       c1_edge,
  output logic       c2_edge,
  output logic       c2_oe,
  output logic       c2_out
);

  logic [7:0] pin_s1;
  // [0] first flop, [1] synchronized level, [2] previous synchronized level
  logic [2:0] c1_s, c2_s;
  logic [2:0] mode;
  logic       c2_reg;

  assign mode = c2_mode;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      or_q     <= '0;
      ddr_q    <= '0;
      pin_s1   <= '0;
      pin_sync <= '0;
      c1_s     <= '0;
      c2_s     <= '0;
      c2_reg   <= 1'b1;
    end else begin
      if (wr_or)  or_q  <= wdata;
      if (wr_ddr) ddr_q <= wdata;
      pin_s1   <= pin_in;
      pin_sync <= pin_s1;
      c1_s     <= {c1_s[1:0], c1_in};
      c2_s     <= {c2_s[1:0], c2_in};
      case (c2_mode)
        C2_HANDSHAKE: begin
          if (hs_access)    c2_reg <= 1'b0;
          else if (c1_edge) c2_reg <= 1'b1;
        end
        C2_PULSE: c2_reg <= ~hs_access;
        C2_LOW:   c2_reg <= 1'b0;
        default:  c2_reg <= 1'b1;
      endcase
    end
  end

  assign c1_edge = c1_pos ? (c1_s[1] & ~c1_s[2]) : (~c1_s[1] & c1_s[2]);
  assign c2_edge = ~mode[2] & (mode[1] ? (c2_s[1] & ~c2_s[2]) : (~c2_s[1] & c2_s[2]));
  assign c2_oe   = mode[2];
  assign c2_out  = c2_reg;

endmodule

// File: rtl/wb_6522_via.sv
// Wishbone B4-classic MOS 6522 VIA subset: ports A/B, CA/CB lines, T1/T2, IFR/IER.
// Timer 2 is present only when VIA_TIMER2_EN is defined.
module wb_6522_via
  import wb_6522_via_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic [WB_ADDR_WIDTH-1:0] adr_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic                     ack_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  output logic                     irq,
  input  logic                     ca1,
  input  logic                     cb1,
  inout  wire                      ca2,
  inout  wire                      cb2,
  inout  wire  [7:0]               port_a,
  inout  wire  [7:0]               port_b
);

  logic       acc, wr, rd;
  logic [3:0] a;
  logic [7:0] wdata, rdata;
  logic [7:0] ora, ddra, pa_sync, orb, ddrb, pb_sync;
  logic       ca1_edge, ca2_edge, ca2_oe, ca2_out;
  logic       cb1_edge, cb2_edge, cb2_oe, cb2_out;
  logic [7:0] sr, acr, pcr;
  logic [6:0] ifr, ier, ifr_set, ifr_clr;
  c2_mode_e   ca2_mode, cb2_mode;

  assign acc      = stb_i & ~ack_o;
  assign wr       = acc & we_i;
  assign rd       = acc & ~we_i;
  assign a        = adr_i[3:0];
  assign wdata    = dat_i[7:0];
  assign ca2_mode = c2_mode_e'(pcr[3:1]);
  assign cb2_mode = c2_mode_e'(pcr[7:5]);

  via_port_ctl u_port_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_or(wr && (a == REG_ORA || a == REG_ORA_NH)), .wr_ddr(wr && a == REG_DDRA),
    .wdata(wdata), .pin_in(port_a), .c1_in(ca1), .c2_in(ca2),
    .c1_pos(pcr[0]), .c2_mode(ca2_mode), .hs_access(acc && a == REG_ORA),
    .or_q(ora), .ddr_q(ddra), .pin_sync(pa_sync),
    .c1_edge(ca1_edge), .c2_edge(ca2_edge), .c2_oe(ca2_oe), .c2_out(ca2_out)
  );

  via_port_ctl u_port_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_or(wr && a == REG_ORB), .wr_ddr(wr && a == REG_DDRB),
    .wdata(wdata), .pin_in(port_b), .c1_in(cb1), .c2_in(cb2),
    .c1_pos(pcr[4]), .c2_mode(cb2_mode), .hs_access(wr && a == REG_ORB),
    .or_q(orb), .ddr_q(ddrb), .pin_sync(pb_sync),
    .c1_edge(cb1_edge), .c2_edge(cb2_edge), .c2_oe(cb2_oe), .c2_out(cb2_out)
  );

  for (genvar i = 0; i < 8; i++) begin : g_pin
    assign port_a[i] = ddra[i] ? ora[i] : 1'bz;
    assign port_b[i] = ddrb[i] ? orb[i] : 1'bz;
  end
  assign ca2 = ca2_oe ? ca2_out : 1'bz;
  assign cb2 = cb2_oe ? cb2_out : 1'bz;

  // T1: free-run passes through FFFF for one cycle before reloading (period N+2)
  logic [15:0] t1_cnt;
  logic [7:0]  t1_ll, t1_lh;
  logic        t1_armed, t1_reload, t1_load, t1_fire;

  assign t1_load = wr && a == REG_T1CH;
  assign t1_fire = t1_armed && t1_cnt == 16'h0 && !t1_reload && !t1_load;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      t1_cnt    <= '0;
      t1_ll     <= '0;
      t1_lh     <= '0;
      t1_armed  <= 1'b0;
      t1_reload <= 1'b0;
    end else begin
      if (wr && (a == REG_T1CL || a == REG_T1LL)) t1_ll <= wdata;
      if (t1_load) begin
        t1_lh     <= wdata;
        t1_cnt    <= {wdata, t1_ll};
        t1_armed  <= 1'b1;
        t1_reload <= 1'b0;
      end else begin
        if (wr && a == REG_T1LH) t1_lh <= wdata;
        if (t1_reload) begin
          t1_cnt    <= {t1_lh, t1_ll};
          t1_reload <= 1'b0;
        end else begin
          t1_cnt <= t1_cnt - 16'd1;
          if (t1_cnt == 16'h0) begin
            if (acr[6]) t1_reload <= 1'b1;
            else        t1_armed  <= 1'b0;
          end
        end
      end
    end
  end

  logic       t2_fire, t2_clr;
  logic [7:0] t2_rd;
`ifdef VIA_TIMER2_EN
  logic [15:0] t2_cnt;
  logic [7:0]  t2_ll;
  logic        t2_armed, t2_load, pb6_q;

  assign t2_load = wr && a == REG_T2CH;
  assign t2_fire = t2_armed && t2_cnt == 16'h0 && !t2_load;
  assign t2_clr  = t2_load || (rd && a == REG_T2CL);
  assign t2_rd   = (a == REG_T2CL) ? t2_cnt[7:0] : t2_cnt[15:8];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      t2_cnt   <= '0;
      t2_ll    <= '0;
      t2_armed <= 1'b0;
      pb6_q    <= 1'b0;
    end else begin
      pb6_q <= pb_sync[6];
      if (wr && a == REG_T2CL) t2_ll <= wdata;
      if (t2_load) begin
        t2_cnt   <= {wdata, t2_ll};
        t2_armed <= 1'b1;
      end else begin
        if (t2_fire) t2_armed <= 1'b0;
        if (!acr[5] || (pb6_q && !pb_sync[6])) t2_cnt <= t2_cnt - 16'd1;
      end
    end
  end
`else
  assign t2_fire = 1'b0;
  assign t2_clr  = 1'b0;
  assign t2_rd   = 8'h00;
`endif

  always_comb begin
    ifr_set          = '0;
    ifr_set[IFR_CA2] = ca2_edge;
    ifr_set[IFR_CA1] = ca1_edge;
    ifr_set[IFR_SR]  = 1'b0;
    ifr_set[IFR_CB2] = cb2_edge;
    ifr_set[IFR_CB1] = cb1_edge;
    ifr_set[IFR_T2]  = t2_fire;
    ifr_set[IFR_T1]  = t1_fire;
    ifr_clr          = '0;
    if (wr && a == REG_IFR) ifr_clr = wdata[6:0];
    if (t1_load || (wr && a == REG_T1LH) || (rd && a == REG_T1CL)) ifr_clr[IFR_T1] = 1'b1;
    if (t2_clr) ifr_clr[IFR_T2] = 1'b1;
    if (acc && a == REG_ORA) begin
      ifr_clr[IFR_CA1] = 1'b1;
      if (!c2_independent(ca2_mode)) ifr_clr[IFR_CA2] = 1'b1;
    end
    if (acc && a == REG_ORB) begin
      ifr_clr[IFR_CB1] = 1'b1;
      if (!c2_independent(cb2_mode)) ifr_clr[IFR_CB2] = 1'b1;
    end
  end

  assign irq = |(ifr & ier);

  always_comb begin
    case (a)
      REG_ORB:              rdata = (orb & ddrb) | (pb_sync & ~ddrb);
      REG_ORA, REG_ORA_NH:  rdata = pa_sync;
      REG_DDRB:             rdata = ddrb;
      REG_DDRA:             rdata = ddra;
      REG_T1CL:             rdata = t1_cnt[7:0];
      REG_T1CH:             rdata = t1_cnt[15:8];
      REG_T1LL:             rdata = t1_ll;
      REG_T1LH:             rdata = t1_lh;
      REG_T2CL, REG_T2CH:   rdata = t2_rd;
      REG_SR:               rdata = sr;
      REG_ACR:              rdata = acr;
      REG_PCR:              rdata = pcr;
      REG_IFR:              rdata = {irq, ifr};
      default:              rdata = {1'b1, ier};
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      sr    <= '0;
      acr   <= '0;
      pcr   <= '0;
      ifr   <= '0;
      ier   <= '0;
    end else begin
      ack_o <= acc;
      if (rd) dat_o <= WB_DATA_WIDTH'(rdata);
      if (wr && a == REG_SR)  sr  <= wdata;
      if (wr && a == REG_ACR) acr <= wdata;
      if (wr && a == REG_PCR) pcr <= wdata;
      if (wr && a == REG_IER) ier <= wdata[7] ? (ier | wdata[6:0]) : (ier & ~wdata[6:0]);
      ifr <= (ifr & ~ifr_clr) | ifr_set;
    end
  end

endmodule

// File: tb/tb_wb_6522_via.sv
// Directed bench for wb_6522_via; read results go through an expected-value queue.
module tb_wb_6522_via;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       stb_i = 1'b0;
  logic       we_i  = 1'b0;
  logic [3:0] adr_i = 4'h0;
  logic [7:0] dat_i = 8'h00;
  logic       ack_o;
  logic [7:0] dat_o;
  logic       irq;
  logic       ca1 = 1'b0;
  logic       cb1 = 1'b0;
  wire        ca2, cb2;
  wire  [7:0] port_a, port_b;
  logic [7:0] pa_en = 8'h00, pa_drv = 8'h00, pb_en = 8'h00, pb_drv = 8'h00;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  for (genvar i = 0; i < 8; i++) begin : g_drv
    assign port_a[i] = pa_en[i] ? pa_drv[i] : 1'bz;
    assign port_b[i] = pb_en[i] ? pb_drv[i] : 1'bz;
  end

  wb_6522_via dut (
    .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .irq(irq),
    .ca1(ca1), .cb1(cb1), .ca2(ca2), .cb2(cb2), .port_a(port_a), .port_b(port_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic w, input logic [3:0] a, input logic [7:0] d,
                           output logic [7:0] q, output logic ok);
    @(negedge clk_i);
    stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (ack_o) begin ok = 1'b1; break; end
    end
    q = dat_o;
    stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] q; logic ok;
    wb_access(1'b1, a, d, q, ok);
    check("wr_ack", {7'd0, ok}, 8'h01);
  endtask

  task automatic wb_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] q; logic ok;
    exp_q.push_back(exp);
    wb_access(1'b0, a, 8'h00, q, ok);
    check("rd_ack", {7'd0, ok}, 8'h01);
    check(tag, q, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_ack_hold", {7'd0, ack_o}, 8'h00);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_dat", dat_o, 8'h00);
    wb_read(4'hD, 8'h00, "rst_ifr");
    wb_read(4'hE, 8'h80, "rst_ier");
    wb_read(4'hB, 8'h00, "rst_acr");
    wb_read(4'h3, 8'h00, "rst_ddra");

    // Ports
    wb_write(4'h3, 8'hFF);
    wb_write(4'h1, 8'hA5);
    check("port_a_drive", port_a, 8'hA5);
    wb_write(4'h3, 8'h0F);
    wb_write(4'hF, 8'h0C);
    pa_drv = 8'h30; pa_en = 8'hF0;
    repeat (3) @(negedge clk_i);
    wb_read(4'h1, 8'h3C, "ira_pins");
    wb_read(4'h3, 8'h0F, "ddra_rb");
    wb_write(4'h2, 8'hF0);
    wb_write(4'h0, 8'hA5);
    pb_drv = 8'h06; pb_en = 8'h0F;
    repeat (3) @(negedge clk_i);
    wb_read(4'h0, 8'hA6, "irb_mix");

    // T1 one-shot: load 0005, flag 6 cycles after the load ack
    wb_write(4'hE, 8'hC0);
    wb_write(4'hB, 8'h00);
    wb_write(4'h4, 8'h05);
    wb_write(4'h5, 8'h00);
    repeat (5) @(negedge clk_i);
    check("t1_irq_early", {7'd0, irq}, 8'h00);
    @(negedge clk_i);
    check("t1_irq_rise", {7'd0, irq}, 8'h01);
    wb_read(4'hD, 8'hC0, "t1_ifr");
    wb_read(4'h4, 8'hFC, "t1_cnt_wrap");
    check("t1_rd_clr_irq", {7'd0, irq}, 8'h00);
    wb_read(4'hD, 8'h00, "t1_ifr_clr");
    repeat (30) @(negedge clk_i);
    check("t1_single", {7'd0, irq}, 8'h00);

    // T1 free-run: latch 0003, period 5
    wb_write(4'hB, 8'h40);
    wb_write(4'h4, 8'h03);
    wb_write(4'h5, 8'h00);
    repeat (3) @(negedge clk_i);
    check("fr_early", {7'd0, irq}, 8'h00);
    @(negedge clk_i);
    check("fr_first", {7'd0, irq}, 8'h01);
    wb_write(4'hD, 8'h40);
    check("fr_clr1", {7'd0, irq}, 8'h00);
    repeat (2) @(negedge clk_i);
    check("fr_gap2", {7'd0, irq}, 8'h00);
    @(negedge clk_i);
    check("fr_second", {7'd0, irq}, 8'h01);
    wb_write(4'hD, 8'h40);
    check("fr_clr2", {7'd0, irq}, 8'h00);
    repeat (2) @(negedge clk_i);
    check("fr_gap3", {7'd0, irq}, 8'h00);
    @(negedge clk_i);
    check("fr_third", {7'd0, irq}, 8'h01);
    wb_write(4'hE, 8'h40);
    check("fr_ier_mask", {7'd0, irq}, 8'h00);
    wb_read(4'hD, 8'h40, "fr_ifr_masked");
    wb_write(4'hB, 8'h00);
    repeat (10) @(negedge clk_i);
    wb_write(4'hD, 8'h7F);
    wb_write(4'hE, 8'h7F);
    repeat (20) @(negedge clk_i);
    wb_read(4'hD, 8'h00, "t1_stopped");

    // CA1 rising edge, 3-cycle synchronizer latency
    wb_write(4'hC, 8'h01);
    wb_write(4'hE, 8'h82);
    @(negedge clk_i);
    ca1 = 1'b1;
    repeat (2) @(negedge clk_i);
    check("ca1_early", {7'd0, irq}, 8'h00);
    @(negedge clk_i);
    check("ca1_irq", {7'd0, irq}, 8'h01);
    wb_read(4'hD, 8'h82, "ca1_ifr");
    wb_read(4'hF, 8'h3C, "ira_nohs");
    wb_read(4'hD, 8'h82, "ca1_keep");
    wb_read(4'h1, 8'h3C, "ira_hs");
    check("ca1_clr_irq", {7'd0, irq}, 8'h00);
    wb_read(4'hD, 8'h00, "ca1_clr");

    // CA2 pulse mode
    wb_write(4'hC, 8'h0A);
    check("ca2_idle", {7'd0, ca2}, 8'h01);
    wb_write(4'h1, 8'h0C);
    check("ca2_pulse", {7'd0, ca2}, 8'h00);
    @(negedge clk_i);
    check("ca2_after", {7'd0, ca2}, 8'h01);

    // T2
    wb_write(4'hE, 8'h7F);
`ifdef VIA_TIMER2_EN
    wb_write(4'hE, 8'hA0);
    wb_write(4'h8, 8'h02);
    wb_write(4'h9, 8'h00);
    repeat (2) @(negedge clk_i);
    check("t2_early", {7'd0, irq}, 8'h00);
    @(negedge clk_i);
    check("t2_irq", {7'd0, irq}, 8'h01);
    wb_read(4'hD, 8'hA0, "t2_ifr");
    wb_write(4'hD, 8'h20);
    check("t2_clr", {7'd0, irq}, 8'h00);
    repeat (20) @(negedge clk_i);
    check("t2_once", {7'd0, irq}, 8'h00);
`else
    wb_write(4'h9, 8'h01);
    wb_read(4'h8, 8'h00, "t2_off_lo");
    wb_read(4'h9, 8'h00, "t2_off_hi");
    repeat (5) @(negedge clk_i);
    wb_read(4'hD, 8'h00, "t2_off_ifr");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
